// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between the IF and DM ports of the pipeline.
// DM wins ties unless IF has waited through STARVE_MAX consecutive DM grants.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   output logic              dm_ack_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o
);

   localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);
   localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
   localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);
   localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state;
   logic [LAT_W-1:0] lat_cnt;
   logic [STV_W-1:0] starve_cnt;
   logic             win_dm;
   logic             grant_dm;
   logic             grant_if;

   // IF is forced only when both ports compete and its starvation budget is spent.
   always_comb begin
      grant_dm = dm_req_i & ~(if_req_i & (starve_cnt == STV_LIM));
      grant_if = if_req_i & ~grant_dm;
   end

   assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         lat_cnt     <= '0;
         starve_cnt  <= '0;
         win_dm      <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_ack_o    <= 1'b0;
         dm_ack_o    <= 1'b0;
         if_rdata_o  <= '0;
         dm_rdata_o  <= '0;
      end else begin
         mem_req_o <= 1'b0;
         if_ack_o  <= 1'b0;
         dm_ack_o  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_dm | grant_if) begin
                  state       <= S_WAIT;
                  mem_req_o   <= 1'b1;
                  lat_cnt     <= LAT_LOAD;
                  win_dm      <= grant_dm;
                  mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
                  mem_we_o    <= grant_dm & dm_we_i;
                  mem_wdata_o <= grant_dm ? dm_wdata_i : '0;
                  if (grant_dm && if_req_i) begin
                     if (starve_cnt != STV_LIM)
                        starve_cnt <= starve_cnt + STV_ONE;
                  end else begin
                     starve_cnt <= '0;
                  end
               end
            end
            S_WAIT: begin
               if (lat_cnt == '0) begin
                  state <= S_RESP;
                  if (win_dm) begin
                     dm_ack_o <= 1'b1;
                     if (!mem_we_o)
                        dm_rdata_o <= mem_rdata_i;
                  end else begin
                     if_ack_o   <= 1'b1;
                     if_rdata_o <= mem_rdata_i;
                  end
               end else begin
                  lat_cnt <= lat_cnt - LAT_ONE;
               end
            end
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   a_ack_exclusive: assert property (@(posedge clk_i) disable iff (rst_i) !(if_ack_o && dm_ack_o));
   a_strobe_in_wait: assert property (@(posedge clk_i) disable iff (rst_i) mem_req_o |-> (state == S_WAIT));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a latency-accurate memory model, per-port
// requesters, and a monitor that pops expected transactions at each command strobe.
module tb_mem_port_arbiter;

   localparam int unsigned MEM_LAT    = 2;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned GAP        = MEM_LAT + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        stall;

   mem_port_arbiter #(
      .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX), .ADDR_W(32), .DATA_W(32)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
      .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .stall_o(stall)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic        is_dm;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int unsigned gap;
   } txn_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        drop;
   } cmd_t;

   txn_t        exp_q[$];
   cmd_t        if_q[$];
   cmd_t        dm_q[$];
   logic [31:0] bmem [logic [31:0]];

   function automatic logic [31:0] init_data(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return bmem.exists(a) ? bmem[a] : init_data(a);
   endfunction

   task automatic push_exp(input logic is_dm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int unsigned gap);
      txn_t t;
      t.is_dm = is_dm; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.gap = gap;
      exp_q.push_back(t);
   endtask

   task automatic push_cmd(input logic is_dm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic drop);
      cmd_t c;
      c.we = we; c.addr = addr; c.wdata = wdata; c.drop = drop;
      if (is_dm) dm_q.push_back(c);
      else if_q.push_back(c);
   endtask

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / memory model / requester state
   int unsigned mlat = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   logic        out_valid = 1'b0;
   txn_t        cur;
   int unsigned s_cyc = 0;
   int unsigned last_strobe = 0;
   logic        have_last = 1'b0;
   logic [31:0] hold_if = '0;
   logic [31:0] hold_dm = '0;
   logic        at_ack;
   logic        exp_if_ack;
   logic        exp_dm_ack;
   logic        strobe_dm_now;
   logic        dm_dropped = 1'b0;

   always @(negedge clk) begin
      // backing memory: data is valid only in the cycle MEM_LAT-1 after the strobe
      mem_rdata = 32'h0BAD_F00D;
      if (rst) begin
         pend      = 1'b0;
         out_valid = 1'b0;
         have_last = 1'b0;
         hold_if   = '0;
         hold_dm   = '0;
      end else begin
         if (mem_req) begin
            if (mem_we) bmem[mem_addr] = mem_wdata;
            pend      = 1'b1;
            pend_addr = mem_addr;
            mlat      = MEM_LAT - 1;
         end else if (pend) begin
            mlat--;
         end
         if (pend && mlat == 0) begin
            mem_rdata = mem_read(pend_addr);
            pend      = 1'b0;
         end
      end

      // response checks
      at_ack     = out_valid && (cyc == s_cyc + MEM_LAT);
      exp_if_ack = at_ack && !cur.is_dm;
      exp_dm_ack = at_ack && cur.is_dm;
      if (out_valid) begin
         check_eq("mem_addr_stable", mem_addr, cur.addr);
         if (cur.we) check_eq("mem_wdata_stable", mem_wdata, cur.wdata);
      end
      check_eq("if_ack", if_ack, exp_if_ack);
      check_eq("dm_ack", dm_ack, exp_dm_ack);
      check_eq("stall", stall, (if_req & ~exp_if_ack) | (dm_req & ~exp_dm_ack));
      if (exp_if_ack) hold_if = cur.rdata;
      if (exp_dm_ack && !cur.we) hold_dm = cur.rdata;
      check_eq(exp_if_ack ? "if_rdata" : "if_rdata_hold", if_rdata, hold_if);
      check_eq(exp_dm_ack ? "dm_rdata" : "dm_rdata_hold", dm_rdata, hold_dm);
      if (at_ack) out_valid = 1'b0;

      // command strobe: pop next expected transaction
      strobe_dm_now = 1'b0;
      if (mem_req && !rst) begin
         check_eq("strobe_overlap", out_valid, 1'b0);
         check_eq("strobe_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check_eq("mem_addr", mem_addr, cur.addr);
            check_eq("mem_we", mem_we, cur.we);
            if (cur.we) check_eq("mem_wdata", mem_wdata, cur.wdata);
            if (have_last && cur.gap != 0)
               check_eq("strobe_gap", cyc - last_strobe, cur.gap);
            else if (have_last)
               check_eq("strobe_gap_min", (cyc - last_strobe) >= GAP, 1'b1);
            s_cyc         = cyc;
            last_strobe   = cyc;
            have_last     = 1'b1;
            out_valid     = 1'b1;
            strobe_dm_now = cur.is_dm;
         end
      end

      // requesters: hold each request until its ack, then present the next one
      if (if_ack && if_q.size() != 0) void'(if_q.pop_front());
      if (if_q.size() != 0) begin
         if_req  = 1'b1;
         if_addr = if_q[0].addr;
      end else begin
         if_req = 1'b0;
      end
      if (dm_ack && dm_q.size() != 0) begin
         void'(dm_q.pop_front());
         dm_dropped = 1'b0;
      end
      if (dm_q.size() != 0) begin
         if (dm_q[0].drop && strobe_dm_now) dm_dropped = 1'b1;
         if (dm_dropped) begin
            dm_req   = 1'b0;
            dm_we    = 1'b0;
            dm_addr  = 32'hFFFF_FFF0;
            dm_wdata = '1;
         end else begin
            dm_req   = 1'b1;
            dm_we    = dm_q[0].we;
            dm_addr  = dm_q[0].addr;
            dm_wdata = dm_q[0].wdata;
         end
      end else begin
         dm_req = 1'b0;
         dm_we  = 1'b0;
      end
   end

   task automatic wait_done(input int unsigned budget);
      int unsigned n = 0;
      logic busy;
      busy = 1'b1;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
         busy = (exp_q.size() != 0) || (if_q.size() != 0) || (dm_q.size() != 0) || out_valid;
      end
      check_eq("txn_timeout", busy, 1'b0);
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_mem_req", mem_req, 1'b0);
      check_eq("rst_mem_we", mem_we, 1'b0);
      check_eq("rst_mem_addr", mem_addr, 32'h0);
      check_eq("rst_mem_wdata", mem_wdata, 32'h0);
      check_eq("rst_if_ack", if_ack, 1'b0);
      check_eq("rst_dm_ack", dm_ack, 1'b0);
      check_eq("rst_if_rdata", if_rdata, 32'h0);
      check_eq("rst_dm_rdata", dm_rdata, 32'h0);
      check_eq("rst_stall", stall, 1'b0);
      rst = 1'b0;

      // single IF read
      bmem[32'h4] = 32'h8C01_0000;
      push_exp(1'b0, 1'b0, 32'h4, '0, 32'h8C01_0000, 0);
      push_cmd(1'b0, 1'b0, 32'h4, '0, 1'b0);
      wait_done(40);

      // simultaneous requests: DM first, IF strobe exactly MEM_LAT+2 later
      push_exp(1'b1, 1'b0, 32'h10, '0, init_data(32'h10), 0);
      push_exp(1'b0, 1'b0, 32'h8, '0, init_data(32'h8), GAP);
      push_cmd(1'b1, 1'b0, 32'h10, '0, 1'b0);
      push_cmd(1'b0, 1'b0, 32'h8, '0, 1'b0);
      wait_done(60);

      // starvation: four DM grants, IF forced, counter cleared so DM wins the next tie
      for (int i = 0; i < 4; i++)
         push_exp(1'b1, 1'b0, 32'h100 + 32'(4 * i), '0, init_data(32'h100 + 32'(4 * i)), (i == 0) ? 0 : GAP);
      push_exp(1'b0, 1'b0, 32'h200, '0, init_data(32'h200), GAP);
      push_exp(1'b1, 1'b0, 32'h110, '0, init_data(32'h110), GAP);
      push_exp(1'b0, 1'b0, 32'h204, '0, init_data(32'h204), GAP);
      for (int i = 0; i < 5; i++) push_cmd(1'b1, 1'b0, 32'h100 + 32'(4 * i), '0, 1'b0);
      push_cmd(1'b0, 1'b0, 32'h200, '0, 1'b0);
      push_cmd(1'b0, 1'b0, 32'h204, '0, 1'b0);
      wait_done(150);

      // DM write, then read it back through IF
      push_exp(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, '0, 0);
      push_cmd(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0);
      wait_done(40);
      push_exp(1'b0, 1'b0, 32'h20, '0, 32'hDEAD_BEEF, 0);
      push_cmd(1'b0, 1'b0, 32'h20, '0, 1'b0);
      wait_done(40);

      // DM drops its request (and scrambles addr) right after the grant
      push_exp(1'b1, 1'b0, 32'h40, '0, init_data(32'h40), 0);
      push_cmd(1'b1, 1'b0, 32'h40, '0, 1'b1);
      wait_done(40);

      // reset during the command: nothing acked, held IF request re-granted after release
      push_exp(1'b0, 1'b0, 32'h44, '0, init_data(32'h44), 0);
      push_cmd(1'b0, 1'b0, 32'h44, '0, 1'b0);
      begin
         int unsigned n = 0;
         while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
         end
         check_eq("strobe_before_reset", mem_req, 1'b1);
      end
      #1 rst = 1'b1;
      #1;
      check_eq("async_rst_mem_req", mem_req, 1'b0);
      check_eq("async_rst_mem_addr", mem_addr, 32'h0);
      check_eq("async_rst_if_ack", if_ack, 1'b0);
      check_eq("async_rst_if_rdata", if_rdata, 32'h0);
      check_eq("async_rst_dm_rdata", dm_rdata, 32'h0);
      push_exp(1'b0, 1'b0, 32'h44, '0, init_data(32'h44), 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      wait_done(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency backing memory between the instruction-fetch port (IF) and the data-memory port (DM) of the 5-stage pipeline CPU.
- Arbitrates between the two ports, sequences each access, and returns read data through a one-cycle ack.
- Drives a global stall_o that freezes PC/IFID/pipeline registers while any request is outstanding.
- DM has priority; IF gets a bounded-starvation guarantee.

Parameters:
- MEM_LAT, 2, backing-memory read latency in cycles; legal range 1 and up.
- STARVE_MAX, 4, consecutive DM grants allowed while IF waits before IF is forced; legal range 1 and up.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- if_req_i  in  1  IF read request; held until if_ack_o.
- if_addr_i  in  ADDR_W  IF byte address.
- if_ack_o  out  1  one-cycle completion pulse for IF.
- if_rdata_o  out  DATA_W  IF read data; valid while if_ack_o=1 and held after.
- dm_req_i  in  1  DM request; held until dm_ack_o.
- dm_we_i  in  1  1 = write, 0 = read.
- dm_addr_i  in  ADDR_W  DM byte address.
- dm_wdata_i  in  DATA_W  DM write data.
- dm_ack_o  out  1  one-cycle completion pulse for DM.
- dm_rdata_o  out  DATA_W  DM read data; valid while dm_ack_o=1 and held after.
- mem_req_o  out  1  one-cycle command strobe to backing memory.
- mem_we_o  out  1  write enable; qualified by mem_req_o.
- mem_addr_o  out  ADDR_W  command address; stable from issue until return to IDLE.
- mem_wdata_o  out  DATA_W  write data; stable from issue until return to IDLE.
- mem_rdata_i  in  DATA_W  read data; valid in the cycle that is MEM_LAT-1 cycles after the mem_req_o cycle.
- stall_o  out  1  combinational: (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o).

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs, latency counter, starve counter and registered rdata/addr/wdata = 0.
  - stall_o follows its combinational equation.
- State machine (IDLE, WAIT, RESP):
  - IDLE: at edge E0 with any request high, pick a winner. Latch winner id, addr, we, wdata. Go to WAIT. mem_req_o=1 for the single cycle after E0. Counter loads MEM_LAT-1.
  - WAIT: counter decrements each edge. At the edge where it reads 0 (edge E0+MEM_LAT), capture mem_rdata_i into the winner's rdata register (reads only) and go to RESP.
  - RESP: winner's ack=1 for exactly one cycle. Requests are ignored. Next edge returns to IDLE.
- Timing consequences:
  - ack is high in the cycle after edge E0+MEM_LAT.
  - Requester sees ack MEM_LAT+1 cycles after E0.
  - Minimum spacing between command strobes is MEM_LAT+2 cycles.
- Arbitration at the IDLE decision edge:
  - Only dm_req_i high: grant DM. Only if_req_i high: grant IF.
  - Both high: grant DM unless starve_cnt==STARVE_MAX, then grant IF.
- starve_cnt:
  - +1 on a DM grant while if_req_i=1 (saturates at STARVE_MAX).
  - Cleared on any IF grant.
  - Cleared on a DM grant with if_req_i=0.
- Writes:
  - mem_we_o=1 during the command.
  - Write latency is identical to read; dm_ack_o pulses at the same cycle position.
  - dm_rdata_o is not updated.
- IF requests never write; mem_we_o=0 for IF grants.
- Requester drops req before ack: the transaction still completes, ack still pulses, and the data is captured. No abort.
- Requester changes addr after grant: no effect; the latched values are used.
- Reset asserted during WAIT/RESP: the transaction is discarded and no ack is issued. After release, IDLE re-arbitrates any still-held request.
- if_rdata_o / dm_rdata_o hold their last captured value between acks.

Test Plan:
- IF read, MEM_LAT=2: if_req_i=1, if_addr_i=0x00000004, mem_rdata_i=0x8C010000 at the capture cycle.
  - Response: mem_req_o one cycle with mem_addr_o=0x4; if_ack_o one cycle, 3 cycles after the grant edge; if_rdata_o=0x8C010000; stall_o=1 until the ack cycle.
- Simultaneous requests, starve_cnt=0: DM read 0x10 and IF read 0x8.
  - Response: DM served first; one RESP cycle, then IDLE; IF strobe issued MEM_LAT+2 cycles after the DM strobe.
- Starvation, STARVE_MAX=4: DM requests back-to-back with if_req_i held high.
  - Response: DM granted 4 times, 5th grant to IF, starve_cnt cleared, 6th grant DM.
- DM write: dm_we_i=1, addr 0x20, wdata 0xDEADBEEF.
  - Response: mem_we_o=1, mem_wdata_o=0xDEADBEEF for the strobe cycle; dm_ack_o pulses; dm_rdata_o keeps its previous value.
- Reset in WAIT: assert rst_i mid-count.
  - Response: mem_req_o, acks and rdata go to 0 without waiting for a clock edge; no ack appears; after release, a held if_req_i is re-granted from IDLE.
- Early drop: dm_req_i deasserted the cycle after grant.
  - Response: dm_ack_o still pulses with captured data; no second strobe is issued.
